ram_uart_dump: RTL
==================

# ram_uart_dump

Post-execution reader that drains data RAM over a UART serial line. It sits beside `CPU` on the same 6-bit RAM address/read-enable interface. When the CPU asserts its end-of-execution signal (`enable_ram_read`), the block reads every RAM word from address 0 upward. Each 16-bit word is transmitted as two 8N1 bytes, high byte first, so a host can capture the final memory image.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2
- `WORDS`, 64, number of RAM words dumped, addresses 0..WORDS-1; legal 1..64
- `clk` input 1 — single clock; all logic rising-edge.
- `reset` input 1 — synchronous, active-high; one clock; reset is synchronous and active-high.
- `enable_ram_read` input 1 — end-of-execution from `CPU`; a 0→1 transition starts a dump.
- `data_ram` input 16 — RAM read data; valid one cycle after `read_enable_to_ram` (synchronous RAM).
- `address_to_ram` output 6 — RAM word address.
- `read_enable_to_ram` output 1 — one-cycle read strobe.
- `tx` output 1 — UART serial out, idle high.
- `busy` output 1 — high from trigger until last stop bit ends.
- `done` output 1 — high after a complete dump; sticky.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `address_to_ram`=0, `read_enable_to_ram`=0, state IDLE, edge-detect register=0, internal word index=0.
- Edge detect: registered copy of `enable_ram_read`. Trigger = current 1 and registered 0, evaluated only in IDLE. Edges while busy are ignored. A level held high after a dump does not retrigger.
- Main FSM states:
  - **IDLE**: on trigger → READ. Clear `done`, set `busy`, index=0.
  - **READ**: `read_enable_to_ram`=1, `address_to_ram`=index → WAIT.
  - **WAIT**: capture `data_ram` into a 16-bit word register at the end of this cycle → SEND_HI.
  - **SEND_HI**: load byte word[15:8] into the UART shifter; when the byte completes → SEND_LO.
  - **SEND_LO**: load word[7:0]; when the byte completes:
    - if index == WORDS-1 → FINISH;
    - otherwise index+1 → READ.
  - **FINISH**: `busy`=0, `done`=1 → IDLE.
- UART frame, 8N1: start bit 0, data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
  - Baud counter width = clog2(CLKS_PER_BIT); it counts 0..CLKS_PER_BIT-1, then resets.
  - Bit counter counts 0..9.
- `read_enable_to_ram` is 0 in every state except READ. `address_to_ram` holds index in all states; it returns to 0 on reset.
- Block never drives `data_ram`, which is input only. The top level must ensure the CPU is not driving the bus while a dump is in progress.
- Reset mid-dump: on the next edge everything returns to reset values. `tx` goes to 1 immediately, truncating the frame. No resume.

## Timing
- Trigger is sampled at edge E0. READ is active in the cycle after E0. WAIT follows. The HI start bit appears on `tx` in the cycle after the WAIT capture edge, i.e. 3 cycles after E0.
- HI and LO bytes are back-to-back: the LO start bit immediately follows the HI stop bit with no idle cycle.
- Between words: 2 cycles with `tx`=1 (READ, WAIT).
- Per word: 20·CLKS_PER_BIT + 2 cycles.
- Full dump from E0 to `done`=1: WORDS·(20·CLKS_PER_BIT+2) + 2 cycles. `busy` falls in the same cycle that `done` rises.
- `tx` always reflects a registered output; it has no combinational path from inputs.

## Test plan
- Reset idle: hold `reset` 3 cycles, then release with `enable_ram_read`=0 for 100 cycles → `tx`=1, `busy`=0, `done`=0, `read_enable_to_ram`=0 throughout.
- Single dump (CLKS_PER_BIT=4, WORDS=4), RAM = {16'hA55A, 16'h0001, 16'hFF00, 16'h1234}; pulse `enable_ram_read` → bytes A5,5A,00,01,FF,00,12,34 decoded in order; each bit 4 cycles; `done` rises 4·82+2=330 cycles after E0.
- Read strobe check in the same run → exactly 4 `read_enable_to_ram` pulses, each 1 cycle wide, with `address_to_ram` = 0,1,2,3; first pulse in the cycle after E0.
- Level/edge handling: hold `enable_ram_read` high for 1000 cycles → exactly one dump. Toggle it 0→1 mid-dump → ignored, byte count still 8. After `done`, a new 0→1 → `done` clears and a second identical dump runs.
- Reset mid-frame: assert `reset` during bit 3 of byte 2 → next cycle `tx`=1, `busy`=0, `done`=0, address 0. A new trigger then restarts from address 0 with byte A5.
- Full depth (WORDS=64, CLKS_PER_BIT=2), RAM[i]=i·16'h0101 → 128 bytes, ending with 3F,3F; the last `address_to_ram` is 6'd63 with no wrap to 0 before `done`.

Source files
------------

// File: rtl/ram_uart_dump.sv
`default_nettype none
// ============================================================================
// Module   : ram_uart_dump
// Purpose  : On CPU end-of-execution, reads RAM words 0..WORDS-1 and streams
//            each word over an 8N1 UART line, high byte first.
// Revision : 1.0 - initial release
// ============================================================================
module ram_uart_dump #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORDS        = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_ram_read,
    input  logic [15:0] data_ram,
    output logic [5:0]  address_to_ram,
    output logic        read_enable_to_ram,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int                  c_baud_w     = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last  = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one   = c_baud_w'(1);
    localparam logic [5:0]          c_last_index = 6'(WORDS - 1);
    localparam logic [3:0]          c_stop_bit   = 4'd9;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_SEND_HI = 3'd3;
    localparam logic [2:0] S_SEND_LO = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic                r_en_d;
    logic                r_busy;
    logic                r_done;
    logic [5:0]          r_index;
    logic [7:0]          r_lo_byte;

    logic                r_tx;
    logic                r_shifting;
    logic [8:0]          r_frame;
    logic [3:0]          r_bit_cnt;
    logic [c_baud_w-1:0] r_baud_cnt;

    logic                w_trigger;
    logic                w_byte_end;
    logic                w_load;
    logic [7:0]          w_load_byte;

    assign w_trigger  = enable_ram_read & ~r_en_d & (r_state == S_IDLE);
    assign w_byte_end = r_shifting & (r_baud_cnt == c_baud_last) & (r_bit_cnt == c_stop_bit);

    // The HI byte is loaded straight from the RAM bus at the end of WAIT so its
    // start bit is on the line in the very next cycle.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_byte  = 8'h00;
        case (r_state)
            S_IDLE:    if (w_trigger) w_state_next = S_READ;
            S_READ:    w_state_next = S_WAIT;
            S_WAIT: begin
                w_state_next = S_SEND_HI;
                w_load       = 1'b1;
                w_load_byte  = data_ram[15:8];
            end
            S_SEND_HI: begin
                if (w_byte_end) begin
                    w_state_next = S_SEND_LO;
                    w_load       = 1'b1;
                    w_load_byte  = r_lo_byte;
                end
            end
            S_SEND_LO: begin
                if (w_byte_end) begin
                    w_state_next = (r_index == c_last_index) ? S_FINISH : S_READ;
                end
            end
            S_FINISH:  w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_en_d    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_index   <= 6'd0;
            r_lo_byte <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_en_d  <= enable_ram_read;
            if (w_trigger) begin
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_index <= 6'd0;
            end
            if (r_state == S_FINISH) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (r_state == S_WAIT) begin
                r_lo_byte <= data_ram[7:0];
            end
            if ((r_state == S_SEND_LO) && w_byte_end && (r_index != c_last_index)) begin
                r_index <= r_index + 6'd1;
            end
        end
    end

    // r_frame holds the bits still to send after the start bit: data LSB first, then stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx       <= 1'b1;
            r_shifting <= 1'b0;
            r_frame    <= 9'h1FF;
            r_bit_cnt  <= 4'd0;
            r_baud_cnt <= '0;
        end else if (w_load) begin
            r_tx       <= 1'b0;
            r_shifting <= 1'b1;
            r_frame    <= {1'b1, w_load_byte};
            r_bit_cnt  <= 4'd0;
            r_baud_cnt <= '0;
        end else if (r_shifting) begin
            if (r_baud_cnt == c_baud_last) begin
                r_baud_cnt <= '0;
                if (r_bit_cnt == c_stop_bit) begin
                    r_shifting <= 1'b0;
                    r_tx       <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_tx      <= r_frame[0];
                    r_frame   <= {1'b1, r_frame[8:1]};
                end
            end else begin
                r_baud_cnt <= r_baud_cnt + c_baud_one;
            end
        end
    end

    assign address_to_ram     = r_index;
    assign read_enable_to_ram = (r_state == S_READ);
    assign tx                 = r_tx;
    assign busy               = r_busy;
    assign done               = r_done;

endmodule
`default_nettype wire
